// File: rtl/mul4_share_arb.sv
// mul4_share_arb: one 4x4 unsigned multiplier shared by NUM_REQ requesters.
//
// A round-robin arbiter picks one valid requester per cycle and feeds a
// 2-stage pipeline: an issue register (s1), then a product/output register.
// Each result is tagged with the index of the requester that produced it.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ID_W     result tag width, ID_W >= clog2(NUM_REQ)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_a      operand A, requester i uses bits [4i+3:4i]
//   req_b      operand B, same packing as req_a
//   req_ready  one-hot grant; handshake when req_valid[i] & req_ready[i]
//   res_valid  result valid
//   res_data   8-bit product A*B
//   res_id     index of the requester that produced res_data
//   res_ready  consumer accepts the result
//
// Optional build macro MUL4_ARB_STATS_EN adds per-requester 8-bit saturating
// grant counters, read through stat_sel (input) / stat_cnt (output).

module mul4_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  output logic [7:0]           res_data,
  output logic [ID_W-1:0]      res_id,
  input  logic                 res_ready
`ifdef MUL4_ARB_STATS_EN
  ,
  input  logic [ID_W-1:0]      stat_sel,
  output logic [7:0]           stat_cnt
`endif
);

  localparam int unsigned N = NUM_REQ;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;

  logic               found;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] win_oh;
  logic [3:0]         win_a;
  logic [3:0]         win_b;

  logic               s1_valid;
  logic [3:0]         s1_a;
  logic [3:0]         s1_b;
  logic [ID_W-1:0]    s1_id;

  logic               out_adv;
  logic               s1_adv;
  logic               can_issue;
  logic               hs;

  assign out_adv   = !res_valid || res_ready;
  assign s1_adv    = s1_valid && out_adv;
  assign can_issue = !s1_valid || out_adv;

  // Rotating priority search in two passes so that every index is a loop
  // constant: first indices >= rr_ptr, then the wrapped-around lower ones.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    win_oh = '0;
    win_a  = '0;
    win_b  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req_valid[k] && (32'(rr_ptr) <= k)) begin
        found     = 1'b1;
        win_id    = ID_W'(k);
        win_oh[k] = 1'b1;
        win_a     = req_a[4*k +: 4];
        win_b     = req_b[4*k +: 4];
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req_valid[k]) begin
        found     = 1'b1;
        win_id    = ID_W'(k);
        win_oh[k] = 1'b1;
        win_a     = req_a[4*k +: 4];
        win_b     = req_b[4*k +: 4];
      end
    end
  end

  assign hs        = found && can_issue && !rst;
  assign req_ready = hs ? win_oh : '0;
  assign rr_next   = (win_id == ID_W'(N - 1)) ? '0 : win_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      // Issue stage: refills (or empties) whenever it can move on.
      if (can_issue) begin
        s1_valid <= hs;
        if (hs) begin
          s1_a   <= win_a;
          s1_b   <= win_b;
          s1_id  <= win_id;
          rr_ptr <= rr_next;
        end
      end
      // Output stage: held stable under backpressure.
      if (out_adv) begin
        res_valid <= s1_adv;
        if (s1_adv) begin
          res_data <= 8'(s1_a) * 8'(s1_b);
          res_id   <= s1_id;
        end
      end
    end
  end

`ifdef MUL4_ARB_STATS_EN
  logic [7:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) grant_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (hs && win_oh[k] && (grant_cnt[k] != '1))
          grant_cnt[k] <= grant_cnt[k] + 8'd1;
      end
    end
  end

  // Selects outside 0..NUM_REQ-1 match no entry and read 0.
  always_comb begin
    stat_cnt = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (stat_sel == ID_W'(k)) stat_cnt = grant_cnt[k];
    end
  end
`endif

endmodule

// File: tb/tb_mul4_share_arb.sv
// Self-checking bench for mul4_share_arb (NUM_REQ=4, ID_W=3).
// Cycle-by-cycle vector table: each row drives inputs for one cycle and
// holds the expected req_ready and the registered result seen in that cycle.

module tb_mul4_share_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [2:0]  res_id;
  logic        res_ready;
`ifdef MUL4_ARB_STATS_EN
  logic [2:0]  stat_sel;
  logic [7:0]  stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mul4_share_arb #(.NUM_REQ(4), .ID_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
`ifdef MUL4_ARB_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [7:0]  exp_data;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] v,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic rr, input logic [3:0] er,
                              input logic erv, input logic [7:0] ed,
                              input logic [2:0] eid);
    vec_t t;
    t.rst = r; t.valid = v; t.a = a; t.b = b; t.rr = rr;
    t.exp_ready = er; t.exp_rv = erv; t.exp_data = ed; t.exp_id = eid;
    return t;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] RR_A = 16'h4321;  // a_i = i+1
  localparam logic [15:0] RR_B = 16'h3333;  // b_i = 3

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
`ifdef MUL4_ARB_STATS_EN
    stat_sel  = '0;
`endif
    repeat (2) step();
    chk("reset_req_ready", -1, 32'(req_ready), 32'd0);
    chk("reset_res_valid", -1, 32'(res_valid), 32'd0);
    chk("reset_res_data",  -1, 32'(res_data),  32'd0);
    chk("reset_res_id",    -1, 32'(res_id),    32'd0);

    // Basic multiply 2*8 on requester 0.
    vecs.push_back(mk(0, 4'b0001, 16'h0002, 16'h0008, 1, 4'b0001, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 16, 0));
    // Arithmetic corners on requester 2, back to back.
    vecs.push_back(mk(0, 4'b0100, 16'h0000, 16'h0900, 1, 4'b0100, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 16'h0100, 16'h0100, 1, 4'b0100, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 16'h0F00, 16'h0300, 1, 4'b0100, 1, 0, 2));
    vecs.push_back(mk(0, 4'b0100, 16'h0F00, 16'h0F00, 1, 4'b0100, 1, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 45, 2));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 225, 2));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 0));
    // Reset so the round-robin stream starts from requester 0.
    vecs.push_back(mk(1, 4'b1111, RR_A, RR_B, 1, 4'b0000, 0, 0, 0));
    for (int k = 0; k < 12; k++) begin
      vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'(1 << (k % 4)),
                        (k >= 2), 8'((((k + 2) % 4) + 1) * 3),
                        3'((k + 2) % 4)));
    end
    // Reset with result id2 (=9) on the output; next comes backpressure.
    vecs.push_back(mk(1, 4'b1111, RR_A, RR_B, 1, 4'b0000, 1, 9, 2));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b0001, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b0010, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 0, 4'b0000, 1, 3, 0));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b0100, 1, 3, 0));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b1000, 1, 6, 1));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b0001, 1, 9, 2));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b0010, 1, 12, 3));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b0100, 1, 3, 0));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b1000, 1, 6, 1));
    // Reset with two results in flight (id2 on output, id3 in s1).
    vecs.push_back(mk(1, 4'b1111, RR_A, RR_B, 1, 4'b0000, 1, 9, 2));
    vecs.push_back(mk(0, 4'b1111, RR_A, RR_B, 1, 4'b0001, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, RR_A, RR_B, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, RR_A, RR_B, 1, 4'b0000, 1, 3, 0));
    vecs.push_back(mk(0, 4'b0000, RR_A, RR_B, 1, 4'b0000, 0, 0, 0));

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      req_valid = vecs[i].valid;
      req_a     = vecs[i].a;
      req_b     = vecs[i].b;
      res_ready = vecs[i].rr;
      #1;
      chk("req_ready", i, 32'(req_ready), 32'(vecs[i].exp_ready));
      chk("res_valid", i, 32'(res_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) begin
        chk("res_data", i, 32'(res_data), 32'(vecs[i].exp_data));
        chk("res_id",   i, 32'(res_id),   32'(vecs[i].exp_id));
      end
      step();
    end
    rst = 1'b0;

`ifdef MUL4_ARB_STATS_EN
    begin
      int g1;
      g1 = 0;
      rst = 1'b1;
      req_valid = '0;
      res_ready = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 4'b0010;
      for (int k = 0; k < 300; k++) begin
        if (req_ready[1]) g1++;
        step();
      end
      chk("grants_req1", -1, 32'(g1), 32'd300);
      req_valid = 4'b1000;
      repeat (3) step();
      req_valid = '0;
      step();
      stat_sel = 3'd1; #1; chk("stat_sel1", -1, 32'(stat_cnt), 32'd255);
      stat_sel = 3'd3; #1; chk("stat_sel3", -1, 32'(stat_cnt), 32'd3);
      stat_sel = 3'd0; #1; chk("stat_sel0", -1, 32'(stat_cnt), 32'd0);
      stat_sel = 3'd5; #1; chk("stat_sel5", -1, 32'(stat_cnt), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      stat_sel = 3'd1; #1; chk("stat_clr1", -1, 32'(stat_cnt), 32'd0);
      stat_sel = 3'd3; #1; chk("stat_clr3", -1, 32'(stat_cnt), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
